// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures PWM high time in microseconds, flags out-of-range pulses and signal loss
// Defining PWM_CAP_PERIOD_EN adds the rise-to-rise period output period_us.
module pwm_capture #(
   parameter int CLK_VAL_MHZ = 50,
   parameter int MIN_US      = 500,
   parameter int MAX_US      = 2500,
   parameter int TIMEOUT_MS  = 50
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        pwm_in,
   output logic [15:0] pulse_us,
   output logic        pulse_valid,
   output logic        pulse_err,
`ifdef PWM_CAP_PERIOD_EN
   output logic        timeout,
   output logic [15:0] period_us
`else
   output logic        timeout
`endif
);

   localparam int PW = $clog2(CLK_VAL_MHZ);
   localparam int TO_US = TIMEOUT_MS * 1000;
   localparam int IW = $clog2(TO_US + 1);
   localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_VAL_MHZ - 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TO_US);
   localparam logic [15:0]   MIN_V    = 16'(MIN_US);
   localparam logic [15:0]   MAX_V    = 16'(MAX_US);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t        state;
   logic          s1, s2, s3;
   logic [PW-1:0] presc;
   logic [15:0]   width_cnt;
   logic [IW-1:0] idle_cnt;
   logic          cap_pend;
   logic [1:0]    fill;
   logic          armed;
`ifdef PWM_CAP_PERIOD_EN
   logic [15:0]   per_cnt;
`endif

   logic rise, fall, us_tick;

   assign rise    = s2 & ~s3;
   assign fall    = ~s2 & s3;
   assign us_tick = (presc == PRE_MAX);

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic t);
      return (t && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         presc       <= '0;
         width_cnt   <= '0;
         idle_cnt    <= '0;
         cap_pend    <= 1'b0;
         fill        <= '0;
         armed       <= 1'b0;
         state       <= IDLE;
         pulse_us    <= '0;
         pulse_valid <= 1'b0;
         pulse_err   <= 1'b0;
         timeout     <= 1'b0;
`ifdef PWM_CAP_PERIOD_EN
         per_cnt     <= '0;
         period_us   <= '0;
`endif
      end else begin
         s1 <= pwm_in;
         s2 <= s1;
         s3 <= s2;

         // A rise is trusted only once the synchroniser has shown a genuine low
         // after reset, so a pulse already high at release is never measured.
         if (!fill[1])
            fill <= fill + 2'd1;
         if (fill[1] && !s2)
            armed <= 1'b1;

         if (rise || us_tick)
            presc <= '0;
         else
            presc <= presc + 1'b1;

         if (rise || fall)
            idle_cnt <= '0;
         else if (us_tick && idle_cnt != IDLE_MAX)
            idle_cnt <= idle_cnt + 1'b1;

         pulse_valid <= 1'b0;
         pulse_err   <= 1'b0;
         cap_pend    <= 1'b0;

         case (state)
            IDLE: begin
               if (rise && armed) begin
                  state     <= HIGH;
                  width_cnt <= '0;
               end
            end
            HIGH: begin
               width_cnt <= sat_inc(width_cnt, us_tick);
               if (fall) begin
                  state    <= LOW;
                  cap_pend <= 1'b1;
               end
            end
            LOW: begin
               if (rise) begin
                  state     <= HIGH;
                  width_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase

         if (cap_pend) begin
            if (width_cnt >= MIN_V && width_cnt <= MAX_V) begin
               pulse_us    <= width_cnt;
               pulse_valid <= 1'b1;
               timeout     <= 1'b0;
            end else begin
               pulse_err <= 1'b1;
            end
         end

         // Any edge this cycle outranks an expiring idle counter.
         if (!rise && !fall && idle_cnt == IDLE_MAX) begin
            timeout <= 1'b1;
            state   <= IDLE;
         end

`ifdef PWM_CAP_PERIOD_EN
         if (rise)
            per_cnt <= '0;
         else
            per_cnt <= sat_inc(per_cnt, us_tick);
         if (rise && state == LOW)
            period_us <= sat_inc(per_cnt, us_tick);
`endif
      end
   end

endmodule
